// File: rtl/mem_ctrl_pkg.sv
// Shared constants and state encoding for the memory access arbiter.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational round-robin arbiter; ptr=0 favours A on contention.
module rr_arb2 (
  input  logic req_a,
  input  logic req_b,
  input  logic ptr,
  output logic gnt_a,
  output logic gnt_b
);

  always_comb begin
    gnt_a = req_a & (~req_b | ~ptr);
    gnt_b = req_b & (~req_a | ptr);
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the 8x8 memory array between requesters A and B: arbitrate, run the
// select/op handshake, wait for valid or time out, then acknowledge the winner.
module mem_access_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_sel,
  output logic              mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid
);

  // Last ACCESS cycle index before giving up.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              ptr_q;
  logic              win_q;
  logic              op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [TO_W-1:0]   timer_q;
  logic              err_q;
  logic              gnt_a, gnt_b;

  rr_arb2 u_arb (
    .req_a (a_req),
    .req_b (b_req),
    .ptr   (ptr_q),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_a || gnt_b) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (mem_valid || (timer_q == TO_LAST)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, timer, error flag, read data and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_a || gnt_b) begin
            win_q   <= gnt_b;
            op_q    <= gnt_b ? b_we    : a_we;
            addr_q  <= gnt_b ? b_addr  : a_addr;
            wdata_q <= gnt_b ? b_wdata : a_wdata;
          end
        end
        SETUP: timer_q <= '0;
        ACCESS: begin
          if (mem_valid) begin
            err_q <= 1'b0;
            if (op_q == OP_READ) rdata_q <= mem_rdata;
          end else begin
            timer_q <= timer_q + TO_W'(1);
            if (timer_q == TO_LAST) err_q <= 1'b1;
          end
        end
        RESP:    ptr_q <= ~win_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    mem_sel   = (state_q == SETUP) || (state_q == ACCESS);
    mem_op    = op_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rdata     = rdata_q;
    a_ack     = (state_q == RESP) && !win_q;
    b_ack     = (state_q == RESP) && win_q;
    a_err     = a_ack && err_q;
    b_err     = b_ack && err_q;
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter.
module tb_mem_access_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ack, a_err, b_ack, b_err;
  logic [7:0] rdata;
  logic       busy, mem_sel, mem_op;
  logic [2:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       mem_valid;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_err     (a_err),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_err     (b_err),
    .rdata     (rdata),
    .busy      (busy),
    .mem_sel   (mem_sel),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [25:0] all_outs();
    return {a_ack, a_err, b_ack, b_err, busy, mem_sel, mem_op, mem_addr, mem_wdata, rdata};
  endfunction

  always @(negedge clk) check_eq("dual_ack", 32'(a_ack & b_ack), 32'd0);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int  cnt;
    bit  exp_b;
    logic [7:0] exp_rd;

    rst_n = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 3'd0; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 3'd0; b_wdata = 8'h00;
    mem_rdata = 8'h00; mem_valid = 1'b0;

    // Reset held with a_req asserted: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_outs", 32'(all_outs()), 32'd0);
    end
    a_req = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_noack", 32'({a_ack, b_ack, busy}), 32'd0);

    // Contention: A then B alternate over four back-to-back transactions.
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 3'd5; b_wdata = 8'h3C;
    mem_valid = 1'b1; mem_rdata = 8'h5A; exp_rd = 8'h5A;
    for (int t = 0; t < 4; t++) begin
      exp_b = (t % 2) == 1;
      @(negedge clk);
      check_eq("alt_sel", 32'(mem_sel), 32'd1);
      check_eq("alt_op", 32'(mem_op), 32'(exp_b));
      check_eq("alt_addr", 32'(mem_addr), exp_b ? 32'd5 : 32'd1);
      if (exp_b) check_eq("alt_wdata", 32'(mem_wdata), 32'h3C);
      @(negedge clk);
      check_eq("alt_access_noack", 32'({a_ack, b_ack}), 32'd0);
      @(negedge clk);
      check_eq("alt_ack", 32'({a_ack, b_ack}), exp_b ? 32'd1 : 32'd2);
      check_eq("alt_err", 32'({a_err, b_err}), 32'd0);
      check_eq("alt_rdata", 32'(rdata), 32'(exp_rd));
      if (t == 0) mem_rdata = 8'h11;
      if (t == 1) exp_rd = 8'h11;
      if (t == 3) begin a_req = 1'b0; b_req = 1'b0; end
      @(negedge clk);
      check_eq("alt_idle", 32'(busy), 32'd0);
    end

    // Single A read, valid in the first ACCESS cycle: ack three cycles later.
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd3; mem_rdata = 8'hA5; mem_valid = 1'b1;
    @(negedge clk);
    check_eq("rd_setup", 32'({mem_sel, mem_op, mem_addr}), 32'({1'b1, 1'b0, 3'd3}));
    check_eq("rd_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("rd_access", 32'({mem_sel, a_ack}), 32'b10);
    @(negedge clk);
    check_eq("rd_ack", 32'({a_ack, a_err, b_ack}), 32'b100);
    check_eq("rd_rdata", 32'(rdata), 32'hA5);
    check_eq("rd_resp_sel", 32'(mem_sel), 32'd0);
    a_req = 1'b0;
    @(negedge clk);
    check_eq("rd_idle", 32'({busy, a_ack}), 32'd0);
    check_eq("rd_hold_addr", 32'(mem_addr), 32'd3);

    // Timeout: mem_valid never arrives, error after exactly 15 ACCESS cycles.
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd2; mem_rdata = 8'hFF; mem_valid = 1'b0;
    @(negedge clk);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!a_ack && cnt < 40);
    a_req = 1'b0;
    check_eq("to_ack", 32'(a_ack), 32'd1);
    check_eq("to_access_cycles", 32'(cnt - 1), 32'd15);
    check_eq("to_err", 32'(a_err), 32'd1);
    check_eq("to_resp_sel", 32'(mem_sel), 32'd0);
    check_eq("to_rdata", 32'(rdata), 32'hA5);
    @(negedge clk);

    // mem_valid pulsed in IDLE and SETUP is ignored; B served (pointer now B).
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd6; mem_rdata = 8'h77; mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    check_eq("ign_setup_noack", 32'({a_ack, b_ack}), 32'd0);
    @(negedge clk);
    check_eq("ign_access1", 32'({b_ack, mem_sel}), 32'b01);
    @(negedge clk);
    check_eq("ign_access2", 32'({b_ack, mem_sel}), 32'b01);
    mem_valid = 1'b1;
    @(negedge clk);
    check_eq("ign_ack", 32'({a_ack, b_ack, b_err}), 32'b010);
    check_eq("ign_rdata", 32'(rdata), 32'h77);
    b_req = 1'b0; mem_valid = 1'b0;
    @(negedge clk);

    // Reset during ACCESS aborts the transaction without an ack.
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd4; a_wdata = 8'h9E;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_access", 32'({mem_sel, mem_op, mem_wdata}), 32'({1'b1, 1'b1, 8'h9E}));
    rst_n = 1'b0; a_req = 1'b0;
    @(negedge clk);
    check_eq("abort_outs", 32'(all_outs()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_noack", 32'({a_ack, b_ack, busy}), 32'd0);

    // Next request after the abort is served normally.
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd7; mem_rdata = 8'hC3; mem_valid = 1'b1;
    @(negedge clk);
    check_eq("post_setup", 32'({mem_sel, mem_addr}), 32'({1'b1, 3'd7}));
    @(negedge clk);
    @(negedge clk);
    check_eq("post_ack", 32'({a_ack, a_err}), 32'b10);
    check_eq("post_rdata", 32'(rdata), 32'hC3);
    a_req = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
